// File: rtl/pong_pkg.sv
// Shared definitions for the Pong paddle datapath.
// Holds the default screen/paddle geometry, the per-axis movement state
// encoding, the 12-bit colour type and the signed position type used for
// all clamped position arithmetic.
package pong_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PAD_W_DEF    = 20;
  localparam int PAD_H_DEF    = 40;
  localparam int EDGE_OFF_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } axis_state_t;

  typedef logic [11:0] rgb_t;

  // One bit wider than a screen coordinate so that y - speed can go
  // negative before clamping instead of wrapping.
  typedef logic signed [10:0] pos_t;

  function automatic pos_t to_pos(input logic [9:0] v);
    return pos_t'({1'b0, v});
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// Vertical motion for one paddle.
// Conditions the two active-low buttons (2-flop synchroniser plus
// debounce), selects a movement request from the buttons or from ball_y,
// runs the IDLE/UP/DOWN state machine with a speed ramp, and keeps the
// clamped centre-y register.
// Ports:
//   clk_i, rst_i   tick clock, asynchronous active-high reset
//   btn_up_n_i     raw active-low up button (asynchronous)
//   btn_dn_n_i     raw active-low down button (asynchronous)
//   auto_i         1 = track ball_y_i, 0 = follow buttons
//   ball_y_i       ball centre y
//   x_c_o, y_c_o   paddle centre
//   moving_o       state machine is not IDLE
module paddle_axis
  import pong_pkg::*;
#(
  parameter int V_ACTIVE    = SCREEN_H,
  parameter int PADDLE_H    = PAD_H_DEF,
  parameter int DEBOUNCE    = 4,
  parameter int ACCEL_TICKS = 16,
  parameter int MAX_SPEED   = 4,
  parameter int AI_SPEED    = 2,
  parameter int DEADBAND    = 2,
  parameter int X_CENTRE    = 30
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_up_n_i,
  input  logic       btn_dn_n_i,
  input  logic       auto_i,
  input  logic [9:0] ball_y_i,
  output logic [9:0] x_c_o,
  output logic [9:0] y_c_o,
  output logic       moving_o
);

  localparam int SPD_TOP = (MAX_SPEED > AI_SPEED) ? MAX_SPEED : AI_SPEED;
  localparam int SPD_W   = $clog2(SPD_TOP + 1);
  localparam int HOLD_W  = $clog2(ACCEL_TICKS + 1);
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);

  localparam pos_t Y_MIN = pos_t'(PADDLE_H / 2);
  localparam pos_t Y_MAX = pos_t'(V_ACTIVE - PADDLE_H / 2);
  localparam pos_t DBAND = pos_t'(DEADBAND);

  // Index 0 = up button, 1 = down button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            stable_q, stable_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  axis_state_t       state_q, state_d, req;
  logic [SPD_W-1:0]  speed_q, speed_d, cap;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [9:0]        y_q, y_d;
  logic              auto_q;
  logic              moving_q, moving_d;

  pos_t y_s, ball_s, spd_s, y_next;

  function automatic pos_t step_up(input pos_t y, input pos_t s);
    pos_t t;
    t = y - s;
    return (t < Y_MIN) ? Y_MIN : t;
  endfunction

  function automatic pos_t step_dn(input pos_t y, input pos_t s);
    pos_t t;
    t = y + s;
    return (t > Y_MAX) ? Y_MAX : t;
  endfunction

  // The stable level only flips after the synchronised sample has
  // disagreed with it for DEBOUNCE ticks in a row.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    y_s    = to_pos(y_q);
    ball_s = to_pos(ball_y_i);
    req    = IDLE;
    if (auto_i) begin
      if (ball_s + DBAND < y_s)      req = UP;
      else if (ball_s > y_s + DBAND) req = DOWN;
    end else begin
      if (!stable_q[0] && stable_q[1])      req = UP;
      else if (stable_q[0] && !stable_q[1]) req = DOWN;
    end
    cap = auto_i ? SPD_W'(AI_SPEED) : SPD_W'(MAX_SPEED);
  end

  // Any change of request passes through IDLE, which also drops the speed,
  // so a reversal always restarts the ramp from 1.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    hold_d  = hold_q;
    if (auto_i != auto_q) begin
      state_d = IDLE;
      speed_d = '0;
      hold_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = req;
      speed_d = (req == IDLE) ? SPD_W'(0) : SPD_W'(1);
      hold_d  = '0;
    end else if (req != state_q) begin
      state_d = IDLE;
      speed_d = '0;
      hold_d  = '0;
    end else if (hold_q == HOLD_W'(ACCEL_TICKS - 1)) begin
      hold_d = '0;
      if (speed_q < cap) speed_d = speed_q + 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end

    // The step uses the speed being entered, so the tick that enters a
    // moving state already moves by one pixel.
    spd_s  = pos_t'(speed_d);
    y_next = y_s;
    if (state_d == UP)        y_next = step_up(y_s, spd_s);
    else if (state_d == DOWN) y_next = step_dn(y_s, spd_s);
    y_d      = y_next[9:0];
    moving_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stable_q <= 2'b11;
      cnt_q    <= '0;
      state_q  <= IDLE;
      speed_q  <= '0;
      hold_q   <= '0;
      y_q      <= 10'(V_ACTIVE / 2);
      auto_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      sync1_q  <= {btn_dn_n_i, btn_up_n_i};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      speed_q  <= speed_d;
      hold_q   <= hold_d;
      y_q      <= y_d;
      auto_q   <= auto_i;
      moving_q <= moving_d;
    end
  end

  assign x_c_o    = 10'(X_CENTRE);
  assign y_c_o    = y_q;
  assign moving_o = moving_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Two-paddle controller: two independent paddle_axis instances plus the
// combinational per-pixel inside-paddle test and constant colours.
// Ports:
//   clk_1ms, reset            tick clock, asynchronous active-high reset
//   btn_up_n, btn_dn_n [1:0]  raw active-low buttons, [0]=paddle1
//   auto_mode [1:0]           per-paddle ball tracking enable
//   ball_y                    ball centre y
//   x, y                      current pixel
//   paddle1_on, paddle2_on    pixel lies inside the paddle
//   rgb_paddle1/2             paddle colours
//   x_paddle1/2, y_paddle1/2  paddle centres
//   moving [1:0]              per-paddle not IDLE
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int   H_ACTIVE    = SCREEN_W,
  parameter int   V_ACTIVE    = SCREEN_H,
  parameter int   PADDLE_W    = PAD_W_DEF,
  parameter int   PADDLE_H    = PAD_H_DEF,
  parameter int   EDGE_OFF    = EDGE_OFF_DEF,
  parameter int   DEBOUNCE    = 4,
  parameter int   ACCEL_TICKS = 16,
  parameter int   MAX_SPEED   = 4,
  parameter int   AI_SPEED    = 2,
  parameter int   DEADBAND    = 2,
  parameter rgb_t RGB1        = 12'h0F0,
  parameter rgb_t RGB2        = 12'hC0C
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic [1:0] btn_up_n,
  input  logic [1:0] btn_dn_n,
  input  logic [1:0] auto_mode,
  input  logic [9:0] ball_y,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       paddle1_on,
  output logic       paddle2_on,
  output rgb_t       rgb_paddle1,
  output rgb_t       rgb_paddle2,
  output logic [9:0] x_paddle1,
  output logic [9:0] x_paddle2,
  output logic [9:0] y_paddle1,
  output logic [9:0] y_paddle2,
  output logic [1:0] moving
);

  localparam int   X1  = EDGE_OFF + PADDLE_W / 2;
  localparam int   X2  = H_ACTIVE - EDGE_OFF - PADDLE_W / 2;
  localparam pos_t HWS = pos_t'(PADDLE_W / 2);
  localparam pos_t HHS = pos_t'(PADDLE_H / 2);

  function automatic logic hit(input logic [9:0] px, input logic [9:0] py,
                               input logic [9:0] xc, input logic [9:0] yc);
    pos_t pxs, pys, xcs, ycs;
    pxs = to_pos(px);
    pys = to_pos(py);
    xcs = to_pos(xc);
    ycs = to_pos(yc);
    return (pxs >= xcs - HWS) && (pxs < xcs + HWS) &&
           (pys >= ycs - HHS) && (pys < ycs + HHS);
  endfunction

  paddle_axis #(
    .V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .DEBOUNCE(DEBOUNCE),
    .ACCEL_TICKS(ACCEL_TICKS), .MAX_SPEED(MAX_SPEED), .AI_SPEED(AI_SPEED),
    .DEADBAND(DEADBAND), .X_CENTRE(X1)
  ) u_axis1 (
    .clk_i(clk_1ms), .rst_i(reset),
    .btn_up_n_i(btn_up_n[0]), .btn_dn_n_i(btn_dn_n[0]),
    .auto_i(auto_mode[0]), .ball_y_i(ball_y),
    .x_c_o(x_paddle1), .y_c_o(y_paddle1), .moving_o(moving[0])
  );

  paddle_axis #(
    .V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .DEBOUNCE(DEBOUNCE),
    .ACCEL_TICKS(ACCEL_TICKS), .MAX_SPEED(MAX_SPEED), .AI_SPEED(AI_SPEED),
    .DEADBAND(DEADBAND), .X_CENTRE(X2)
  ) u_axis2 (
    .clk_i(clk_1ms), .rst_i(reset),
    .btn_up_n_i(btn_up_n[1]), .btn_dn_n_i(btn_dn_n[1]),
    .auto_i(auto_mode[1]), .ball_y_i(ball_y),
    .x_c_o(x_paddle2), .y_c_o(y_paddle2), .moving_o(moving[1])
  );

  assign paddle1_on  = hit(x, y, x_paddle1, y_paddle1);
  assign paddle2_on  = hit(x, y, x_paddle2, y_paddle2);
  assign rgb_paddle1 = RGB1;
  assign rgb_paddle2 = RGB2;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl at default parameters. Inputs change and
// outputs are sampled on the falling edge; expected values are hand-derived
// tick by tick from the press edge.
module tb_paddle_ctrl;

  logic        clk_1ms = 1'b0;
  logic        reset;
  logic [1:0]  btn_up_n, btn_dn_n, auto_mode;
  logic [9:0]  ball_y, x, y;
  logic        paddle1_on, paddle2_on;
  logic [11:0] rgb_paddle1, rgb_paddle2;
  logic [9:0]  x_paddle1, x_paddle2, y_paddle1, y_paddle2;
  logic [1:0]  moving;

  int n_tests = 0;
  int n_fail  = 0;

  paddle_ctrl dut (
    .clk_1ms(clk_1ms), .reset(reset),
    .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n), .auto_mode(auto_mode),
    .ball_y(ball_y), .x(x), .y(y),
    .paddle1_on(paddle1_on), .paddle2_on(paddle2_on),
    .rgb_paddle1(rgb_paddle1), .rgb_paddle2(rgb_paddle2),
    .x_paddle1(x_paddle1), .x_paddle2(x_paddle2),
    .y_paddle1(y_paddle1), .y_paddle2(y_paddle2),
    .moving(moving)
  );

  always #5 clk_1ms = ~clk_1ms;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1ms);
  endtask

  task automatic pix(input string tag, input int px, input int py,
                     input logic e1, input logic e2);
    x = 10'(px);
    y = 10'(py);
    #1;
    check({tag, "_p1"}, 32'(paddle1_on), 32'(e1));
    check({tag, "_p2"}, 32'(paddle2_on), 32'(e2));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_y1", 32'(y_paddle1), 240);
    check("rst_y2", 32'(y_paddle2), 240);
    check("rst_mv", 32'(moving), 0);
    @(negedge clk_1ms);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_up_n  = 2'b11;
    btn_dn_n  = 2'b11;
    auto_mode = 2'b00;
    ball_y    = '0;
    x         = '0;
    y         = '0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("init_y1", 32'(y_paddle1), 240);
    check("init_y2", 32'(y_paddle2), 240);
    check("init_x1", 32'(x_paddle1), 30);
    check("init_x2", 32'(x_paddle2), 610);
    check("init_mv", 32'(moving), 0);
    check("rgb1", 32'(rgb_paddle1), 32'h0F0);
    check("rgb2", 32'(rgb_paddle2), 32'hC0C);

    // Pixel test at y1 = y2 = 240
    pix("pix_20_220", 20, 220, 1'b1, 1'b0);
    pix("pix_40_240", 40, 240, 1'b0, 1'b0);
    pix("pix_30_260", 30, 260, 1'b0, 1'b0);
    pix("pix_30_259", 30, 259, 1'b1, 1'b0);
    pix("pix_19_240", 19, 240, 1'b0, 1'b0);
    pix("pix_600_240", 600, 240, 1'b0, 1'b1);
    pix("pix_599_240", 599, 240, 1'b0, 1'b0);
    pix("pix_619_220", 619, 220, 1'b0, 1'b1);
    @(negedge clk_1ms);

    // Paddle 1 up: latency, ramp, cap, clamp
    btn_up_n[0] = 1'b0;
    tick(6);
    check("lat6_y1", 32'(y_paddle1), 240);
    check("lat6_mv", 32'(moving[0]), 0);
    tick(1);
    check("lat7_y1", 32'(y_paddle1), 239);
    check("lat7_mv", 32'(moving[0]), 1);
    tick(15);
    check("t22_y1", 32'(y_paddle1), 224);
    tick(1);
    check("spd2_y1", 32'(y_paddle1), 222);
    tick(16);
    check("spd3_y1", 32'(y_paddle1), 189);
    tick(16);
    check("spd4_y1", 32'(y_paddle1), 140);
    tick(16);
    check("cap4_y1", 32'(y_paddle1), 76);
    tick(13);
    check("near_y1", 32'(y_paddle1), 24);
    tick(1);
    check("clamp_y1", 32'(y_paddle1), 20);
    tick(5);
    check("hold_y1", 32'(y_paddle1), 20);
    check("hold_mv", 32'(moving[0]), 1);
    check("indep_y2", 32'(y_paddle2), 240);

    // Asynchronous reset while moving
    btn_up_n = 2'b11;
    pulse_reset();

    // Short glitch on paddle 2 down is rejected
    btn_dn_n[1] = 1'b0;
    tick(3);
    btn_dn_n[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("glitch_mv", 32'(moving[1]), 0);
    end
    check("glitch_y2", 32'(y_paddle2), 240);

    // Both buttons on paddle 1 means no motion
    btn_up_n[0] = 1'b0;
    btn_dn_n[0] = 1'b0;
    tick(12);
    check("both_y1", 32'(y_paddle1), 240);
    check("both_mv", 32'(moving[0]), 0);
    btn_up_n[0] = 1'b1;
    btn_dn_n[0] = 1'b1;
    tick(8);

    // Paddle 2 down to full speed, then reverse
    btn_dn_n[1] = 1'b0;
    tick(7);
    check("dn7_y2", 32'(y_paddle2), 241);
    tick(51);
    check("dn58_y2", 32'(y_paddle2), 352);
    btn_dn_n[1] = 1'b1;
    btn_up_n[1] = 1'b0;
    tick(6);
    check("rev6_y2", 32'(y_paddle2), 376);
    tick(1);
    check("rev_idle_y2", 32'(y_paddle2), 376);
    check("rev_idle_mv", 32'(moving[1]), 0);
    tick(1);
    check("rev_up1_y2", 32'(y_paddle2), 375);
    check("rev_up1_mv", 32'(moving[1]), 1);
    tick(1);
    check("rev_up2_y2", 32'(y_paddle2), 374);
    btn_up_n[1] = 1'b1;
    pulse_reset();

    // Paddle 2 auto tracking ball_y = 100 with its down button held
    auto_mode[1] = 1'b1;
    ball_y       = 10'd100;
    btn_dn_n[1]  = 1'b0;
    tick(1);
    check("auto1_y2", 32'(y_paddle2), 240);
    check("auto1_mv", 32'(moving[1]), 0);
    tick(1);
    check("auto2_y2", 32'(y_paddle2), 239);
    check("auto2_mv", 32'(moving[1]), 1);
    tick(15);
    check("auto17_y2", 32'(y_paddle2), 224);
    tick(1);
    check("auto18_y2", 32'(y_paddle2), 222);
    tick(16);
    check("auto_cap_y2", 32'(y_paddle2), 190);
    tick(1);
    check("auto35_y2", 32'(y_paddle2), 188);
    tick(43);
    check("auto78_y2", 32'(y_paddle2), 102);
    check("auto78_mv", 32'(moving[1]), 1);
    tick(1);
    check("settle_y2", 32'(y_paddle2), 102);
    check("settle_mv", 32'(moving[1]), 0);
    tick(10);
    check("settled_y2", 32'(y_paddle2), 102);
    check("settled_mv", 32'(moving[1]), 0);
    check("auto_y1", 32'(y_paddle1), 240);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
